// File: rtl/siftedkey_bram_reader.sv
// siftedkey_bram_reader: streams sifted-key words from BRAM port B onto a valid/ready link through a prefetch FIFO.
// Optional SIFTKEY_CHECKSUM_EN adds key_checksum, the running XOR of accepted words.
module siftedkey_bram_reader #(
   parameter int ADDR_W       = 15,
   parameter int DATA_W       = 64,
   parameter int READ_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   word_count,
   output logic [ADDR_W-1:0] Bsiftedkey_addrb,
   output logic              Bsiftedkey_enb,
   input  logic [DATA_W-1:0] Bsiftedkey_doutb,
   output logic [DATA_W-1:0] key_data,
   output logic              key_valid,
   input  logic              key_ready,
   output logic              key_last,
   output logic              busy,
   output logic              done
`ifdef SIFTKEY_CHECKSUM_EN
   ,output logic [DATA_W-1:0] key_checksum
`endif
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                  state;
   logic [ADDR_W:0]         count, issued, accepted;
   logic [READ_LATENCY-1:0] tags;
   logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]           rd_ptr, wr_ptr;
   logic [CW-1:0]           fifo_count;
   logic [OW-1:0]           occ;
   logic                    push, pop, credit, last_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   // Occupancy after this edge if nothing new issues: queued + every read still in flight, minus the pop.
   always_comb begin
      occ = OW'(fifo_count) + OW'(Bsiftedkey_enb) - OW'(pop);
      for (int i = 0; i < READ_LATENCY; i++) occ = occ + OW'(tags[i]);
   end

   assign push      = tags[READ_LATENCY-1];
   assign key_valid = fifo_count != '0;
   assign pop       = key_valid & key_ready;
   assign key_data  = key_valid ? fifo_mem[rd_ptr] : '0;
   assign key_last  = key_valid && accepted == count - 1'b1;
   assign credit    = occ < OW'(FIFO_DEPTH);
   assign last_pop  = pop && accepted + 1'b1 == count;

   always_ff @(posedge clk) begin
      if (reset) begin
         tags       <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         tags <= READ_LATENCY'({tags, Bsiftedkey_enb});
         if (push) begin
            fifo_mem[wr_ptr] <= Bsiftedkey_doutb;
            wr_ptr           <= nxt(wr_ptr);
         end
         if (pop) rd_ptr <= nxt(rd_ptr);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         count            <= '0;
         issued           <= '0;
         accepted         <= '0;
         Bsiftedkey_addrb <= '0;
         Bsiftedkey_enb   <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
      end else begin
         Bsiftedkey_enb <= 1'b0;
         done           <= 1'b0;
         if (pop) accepted <= accepted + 1'b1;
         case (state)
            IDLE: if (start) begin
               count    <= word_count;
               accepted <= '0;
               if (word_count == '0) begin
                  state  <= DONE;
                  issued <= '0;
                  done   <= 1'b1;
               end else begin
                  state            <= READ;
                  busy             <= 1'b1;
                  Bsiftedkey_enb   <= 1'b1;
                  Bsiftedkey_addrb <= '0;
                  issued           <= ADDR_W'(1);
               end
            end
            READ: begin
               if (issued == count) state <= DRAIN;
               else if (credit) begin
                  Bsiftedkey_enb   <= 1'b1;
                  Bsiftedkey_addrb <= issued[ADDR_W-1:0];
                  issued           <= issued + 1'b1;
               end
               if (last_pop) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DRAIN: if (last_pop) begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SIFTKEY_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset) key_checksum <= '0;
      else if (state == IDLE && start) key_checksum <= '0;
      else if (pop) key_checksum <= key_checksum ^ key_data;
   end
`endif
endmodule

// File: tb/tb_siftedkey_bram_reader.sv
// tb_siftedkey_bram_reader: scoreboard bench for siftedkey_bram_reader with a 2-cycle BRAM model.
module tb_siftedkey_bram_reader;
   logic        clk, reset, start, key_ready;
   logic [15:0] word_count;
   logic [14:0] addrb;
   logic        enb;
   logic [63:0] doutb, d1, key_data;
   logic        key_valid, key_last, busy, done;
`ifdef SIFTKEY_CHECKSUM_EN
   logic [63:0] key_checksum;
`endif

   siftedkey_bram_reader dut (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count),
      .Bsiftedkey_addrb(addrb), .Bsiftedkey_enb(enb), .Bsiftedkey_doutb(doutb),
      .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
      .key_last(key_last), .busy(busy), .done(done)
`ifdef SIFTKEY_CHECKSUM_EN
      , .key_checksum(key_checksum)
`endif
   );

   logic [63:0] mem [32768];
   logic [64:0] exp_q [$];
   int tests = 0, fails = 0;
   int cyc = 0, t0 = 0, first_valid = -1;
   int enb_total = 0, acc_total = 0, valid_cnt = 0;
   logic [15:0] exp_addr = '0;
   logic        stalled = 1'b0;
   logic [63:0] held = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (enb) d1 <= mem[addrb];
      doutb <= d1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: address order, credit bound, stall stability and scoreboard compare.
   always @(negedge clk) begin
      if (reset) stalled = 1'b0;
      else begin
         if (enb) begin
            check("addrb", 64'(addrb), 64'(exp_addr[14:0]));
            exp_addr++;
            enb_total++;
            check("occupancy_le_4", 64'(enb_total - acc_total <= 4), 64'd1);
         end
         if (stalled) begin
            check("hold_valid", 64'(key_valid), 64'd1);
            check("hold_data", key_data, held);
         end
         if (key_valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
         end
         if (key_valid && key_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", key_data, 64'hx);
            else begin
               logic [64:0] e;
               e = exp_q.pop_front();
               check("key_data", key_data, e[63:0]);
               check("key_last", 64'(key_last), 64'(e[64]));
            end
            acc_total++;
         end
         stalled = key_valid && !key_ready;
         held    = key_data;
      end
   end

   // Called at posedge+1; returns at the done cycle (offset from start cycle) or -1.
   task automatic run(input int n, input bit toggle, output int dcyc);
      int e0, a0;
      exp_addr    = '0;
      first_valid = -1;
      for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, mem[i]});
      e0 = enb_total;
      a0 = acc_total;
      start      = 1'b1;
      word_count = 16'(n);
      t0         = cyc;
      @(posedge clk); #1;
      start      = 1'b0;
      word_count = 16'h0;
      check("busy_after_start", 64'(busy), 64'(n != 0));
      dcyc = -1;
      for (int k = 0; k < 40000 && dcyc < 0; k++) begin
         if (done) dcyc = cyc - t0;
         else begin
            @(posedge clk); #1;
            if (toggle) key_ready = ~key_ready;
         end
      end
      check("done_seen", 64'(dcyc >= 0), 64'd1);
      check("busy_at_done", 64'(busy), 64'd0);
      check("beats", 64'(acc_total - a0), 64'(n));
      check("reads", 64'(enb_total - e0), 64'(n));
      check("queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int dc, v0, e0;
      for (int i = 0; i < 32768; i++) mem[i] = 64'(i) + 64'h1000;
      reset = 1'b1; start = 1'b0; key_ready = 1'b1; word_count = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_enb", 64'(enb), 64'd0);
      check("rst_valid", 64'(key_valid), 64'd0);
      check("rst_busy_done", {busy, done}, 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      run(8, 1'b0, dc);
      check("n8_first_valid", 64'(first_valid - t0), 64'd4);
      check("n8_done_cycle", 64'(dc), 64'd12);
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done), 64'd0);

      key_ready = 1'b1;
      run(16, 1'b1, dc);
      key_ready = 1'b1;
      @(posedge clk); #1;

      v0 = valid_cnt;
      e0 = enb_total;
      run(0, 1'b0, dc);
      check("n0_done_cycle", 64'(dc), 64'd1);
      check("n0_no_valid", 64'(valid_cnt - v0), 64'd0);
      check("n0_no_enb", 64'(enb_total - e0), 64'd0);
      @(posedge clk); #1;

      run(32768, 1'b0, dc);
      check("n32768_done_cycle", 64'(dc), 64'd32772);
      @(posedge clk); #1;

      key_ready  = 1'b0;
      exp_addr   = '0;
      start      = 1'b1;
      word_count = 16'd8;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      acc_total = enb_total;
      check("mid_rst_enb_addr", {enb, addrb}, 64'd0);
      check("mid_rst_valid_last", {key_valid, key_last}, 64'd0);
      check("mid_rst_data", key_data, 64'd0);
      check("mid_rst_busy_done", {busy, done}, 64'd0);
      key_ready = 1'b1;
      run(2, 1'b0, dc);
      check("after_rst_done_cycle", 64'(dc), 64'd6);
      @(posedge clk); #1;

`ifdef SIFTKEY_CHECKSUM_EN
      mem[0] = 64'hF0F0_F0F0_F0F0_F0F0;
      mem[1] = 64'h0F0F_0F0F_0F0F_0F0F;
      mem[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      run(3, 1'b0, dc);
      check("csum_3", key_checksum, 64'd0);
      @(posedge clk); #1;
      run(2, 1'b0, dc);
      check("csum_2", key_checksum, 64'hFFFF_FFFF_FFFF_FFFF);
      @(posedge clk); #1;
      run(1, 1'b0, dc);
      check("csum_cleared", key_checksum, 64'hF0F0_F0F0_F0F0_F0F0);
      @(posedge clk); #1;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/siftedkey_bram_reader.md
# siftedkey_bram_reader

Reads Bob's sifted key out of the sifted-key BRAM after sifting completes. Drives BRAM port B, the read side opposite the sifting engine's port-A writer. Streams the 64-bit key words, in address order, onto a valid/ready interface for the downstream post-processing stage (error estimation / reconciliation). A small prefetch FIFO hides the BRAM read latency and absorbs backpressure.

## Interface
- `ADDR_W`, 15: BRAM address width (depth 32768).
- `DATA_W`, 64: key word width.
- `READ_LATENCY`, 2: BRAM port-B cycles from `enb`/`addrb` to valid `doutb`; legal values 1 or 2.
- `FIFO_DEPTH`, 4: prefetch FIFO entries; must be ≥ READ_LATENCY+2.
- `clk` in 1: single clock, also drives BRAM port B.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; begins a readout.
- `word_count` in ADDR_W+1: number of words to read, 0..32768; sampled on the `start` cycle.
- `Bsiftedkey_addrb` out ADDR_W: BRAM read address.
- `Bsiftedkey_enb` out 1: BRAM read enable.
- `Bsiftedkey_doutb` in DATA_W: BRAM read data.
- `key_data` out DATA_W: streamed key word.
- `key_valid` out 1: `key_data` is valid.
- `key_ready` in 1: downstream accepts the word.
- `key_last` out 1: marks the final word; qualified by `key_valid`.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle pulse when the readout completes.
- `key_checksum` out DATA_W: present only with SIFTKEY_CHECKSUM_EN.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - On `start` with `word_count`>0: latch the count, clear the issue and accept counters, go to READ.
  - On `start` with `word_count`=0: go directly to DONE; no BRAM access, no `key_valid`.
- READ:
  - Issue one read per cycle while (fifo_count + inflight) < FIFO_DEPTH and issued < count.
  - On an issue: `enb`=1, `addrb`=issued[ADDR_W-1:0], issued increments.
  - When issued == count, go to DRAIN.
- Data return:
  - A shift register of depth READ_LATENCY tracks in-flight reads.
  - A returned word is written to the FIFO on the cycle its tag emerges.
  - The credit check guarantees the FIFO never overflows.
- Output:
  - `key_valid` = FIFO non-empty; `key_data` = FIFO head.
  - A pop occurs on `key_valid & key_ready`; `accepted` increments on each pop.
  - `key_last` = `key_valid` & (accepted == count−1).
- DRAIN: when a pop completes accepted == count, go to DONE.
- DONE: assert `done` for one cycle, return to IDLE.
- `start` is ignored while not in IDLE.
- Counters are ADDR_W+1 bits, so a count of 32768 does not wrap. `addrb` uses the low ADDR_W bits and never exceeds 32767.
- Simultaneous FIFO push and pop in one cycle is allowed; occupancy is unchanged.
- `reset` mid-operation:
  - Returns to IDLE and empties the FIFO and in-flight tags.
  - Outputs return to their reset values.
  - BRAM data still returning after reset is discarded.
- Reset values: `addrb`=0, `enb`=0, `key_valid`=0, `key_last`=0, `key_data`=0, `busy`=0, `done`=0, `key_checksum`=0.

## Timing
- Cycle numbering for `start` sampled in cycle 0:
  - `busy`=1 from cycle 1.
  - First `enb` (addr 0) in cycle 1.
  - Data enters the FIFO at end of cycle 1+READ_LATENCY.
  - `key_valid` rises in cycle 2+READ_LATENCY (cycle 4 at the default latency).
- Throughput: 1 word/cycle sustained while `key_ready` is held high.
- Backpressure:
  - `key_ready` low stalls issue once credits are exhausted.
  - `key_data`/`key_valid` hold stable while `key_valid & ~key_ready`.
- `done` asserts the cycle after the final handshake; `busy` falls in that same cycle.
- Zero-count path: `done` in cycle 1; `busy` is never asserted.

## Configuration
- `SIFTKEY_CHECKSUM_EN` defined:
  - `key_checksum` is the running XOR of every accepted word.
  - It clears on an accepted `start` and is valid and stable from the `done` cycle until the next `start`.
- Not defined: the `key_checksum` port and its logic are absent. Stream behaviour is identical either way.

## Test plan
- `word_count`=8, BRAM[i]=i+0x1000, `key_ready`=1 → words 0x1000..0x1007 in order; `key_valid` first in cycle 4; 8 consecutive beats; `key_last` on 0x1007; `done` in cycle 12.
- `word_count`=16, `key_ready` toggling 1,0 each cycle → all 16 words, no loss or duplication; FIFO never exceeds 4 entries; data held stable while stalled.
- `word_count`=0 → `done` in cycle 1; `enb` never asserted; `key_valid` never asserted.
- `word_count`=32768 → `addrb` runs 0..32767 without wrap; exactly 32768 beats; `key_last` on the word from addr 32767.
- `reset` asserted with `key_ready`=0 after 3 words are prefetched → next cycle all outputs at reset values; a new `start` with `word_count`=2 yields addr 0 and addr 1 only.
- With SIFTKEY_CHECKSUM_EN, words {0xF0F0…F0, 0x0F0F…0F, 0xFFFF…FF} → `key_checksum`=0 at `done`; a second `start` clears it before accumulating again.
